// File: rtl/sq_sig_pkg.sv
// Shared definitions for the square-wave self-test source.
//   CNT_W_DEF  : default width of period/high_len and the phase counter
//   LFSR_TAPS  : feedback mask for the 16-bit glitch LFSR (taps 16,14,13,11)
//   state_t    : FSM state encoding (IDLE, RUN)
//   lfsr_next  : one Fibonacci step of the glitch LFSR
package sq_sig_pkg;

    localparam int          CNT_W_DEF = 32;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;  // bits 15,13,12,10

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Shift left; the new LSB is the XOR of the tapped bits.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/sq_sig_glitch_inj.sv
// Glitch injector: free-running LFSR plus a down-counter that holds
// glitch_active high for exactly glitch_len cycles per glitch.
//   clk_100M, rst_n : clock, async active-low reset
//   run             : 1 while the generator is in RUN; 0 aborts any glitch
//   noise_en        : enables LFSR stepping and glitch starts
//   noise_rate      : a glitch starts when LFSR[7:0] < noise_rate
//   glitch_len      : glitch length in cycles (0 disables glitches)
//   glitch_active   : 1 while a glitch is in progress
module sq_sig_glitch_inj
    import sq_sig_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic       clk_100M,
    input  logic       rst_n,
    input  logic       run,
    input  logic       noise_en,
    input  logic [7:0] noise_rate,
    input  logic [7:0] glitch_len,
    output logic       glitch_active
);

    logic [15:0] lfsr;
    logic [7:0]  glitch_cnt;
    logic        start;

    assign glitch_active = (glitch_cnt != 8'd0);

    // Starts are only evaluated once the counter is back at zero, so a new
    // glitch is always separated from the previous one by at least one cycle.
    assign start = run && !glitch_active && noise_en &&
                   (glitch_len != 8'd0) && (lfsr[7:0] < noise_rate);

    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            lfsr       <= LFSR_SEED;
            glitch_cnt <= 8'd0;
        end else begin
            if (noise_en)
                lfsr <= lfsr_next(lfsr);

            // Disabling noise mid-glitch lets the glitch finish; leaving RUN aborts it.
            if (!run)
                glitch_cnt <= 8'd0;
            else if (start)
                glitch_cnt <= glitch_len;
            else if (glitch_active)
                glitch_cnt <= glitch_cnt - 8'd1;
        end
    end

endmodule

// File: rtl/sq_sig_gen.sv
// Programmable square-wave source with an optional glitched copy, used to
// self-test the frequency-meter input path.
//   clk_100M, rst_n : 100 MHz clock, async active-low reset
//   en              : 1 = generate, 0 = idle (outputs low)
//   period          : period in clock cycles (0 = stay idle)
//   high_len        : high cycles per period
//   noise_en        : enable glitch injection
//   noise_rate      : glitch start threshold against LFSR[7:0]
//   glitch_len      : glitch length in cycles
//   sq_sig          : clean square wave, registered
//   sq_sig_noisy    : sq_sig XOR glitch, registered, same cycle as sq_sig
//   period_tick     : 1-cycle pulse on the first cycle of every period
//   busy            : 1 while in RUN
module sq_sig_gen
    import sq_sig_pkg::*;
#(
    parameter int          CNT_W     = CNT_W_DEF,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic             clk_100M,
    input  logic             rst_n,
    input  logic             en,
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] high_len,
    input  logic             noise_en,
    input  logic [7:0]       noise_rate,
    input  logic [7:0]       glitch_len,
    output logic             sq_sig,
    output logic             sq_sig_noisy,
    output logic             period_tick,
    output logic             busy
);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] phase_cnt, phase_nxt;
    logic [CNT_W-1:0] period_sh, period_sh_nxt;
    logic [CNT_W-1:0] high_sh, high_sh_nxt;
    logic             sq_nxt, noisy_nxt, tick_nxt;
    logic             wrap;
    logic             glitch_active;

    assign busy = (state == RUN);

    // phase_cnt never exceeds period_sh-1 and period_sh is never 0 in RUN.
    assign wrap = (phase_cnt == period_sh - CNT_W'(1));

    always_comb begin
        state_nxt     = state;
        phase_nxt     = phase_cnt;
        period_sh_nxt = period_sh;
        high_sh_nxt   = high_sh;
        sq_nxt        = 1'b0;
        tick_nxt      = 1'b0;
        noisy_nxt     = 1'b0;

        case (state)
            IDLE: begin
                if (en && (period != '0)) begin
                    state_nxt     = RUN;
                    phase_nxt     = '0;
                    period_sh_nxt = period;
                    high_sh_nxt   = high_len;
                end
            end
            RUN: begin
                if (!en) begin
                    state_nxt = IDLE;
                    phase_nxt = '0;
                end else begin
                    sq_nxt    = (phase_cnt < high_sh);
                    tick_nxt  = (phase_cnt == '0);
                    // Gated by RUN&&en so a glitch counter still draining
                    // after exit can never leak into IDLE.
                    noisy_nxt = sq_nxt ^ glitch_active;
                    if (wrap) begin
                        // Shadows only reload here, so mid-period edits
                        // never produce a runt period.
                        phase_nxt = '0;
                        if (period == '0) begin
                            state_nxt = IDLE;
                        end else begin
                            period_sh_nxt = period;
                            high_sh_nxt   = high_len;
                        end
                    end else begin
                        phase_nxt = phase_cnt + CNT_W'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            phase_cnt    <= '0;
            period_sh    <= '0;
            high_sh      <= '0;
            sq_sig       <= 1'b0;
            sq_sig_noisy <= 1'b0;
            period_tick  <= 1'b0;
        end else begin
            phase_cnt    <= phase_nxt;
            period_sh    <= period_sh_nxt;
            high_sh      <= high_sh_nxt;
            sq_sig       <= sq_nxt;
            sq_sig_noisy <= noisy_nxt;
            period_tick  <= tick_nxt;
        end
    end

    sq_sig_glitch_inj #(
        .LFSR_SEED (LFSR_SEED)
    ) u_glitch (
        .clk_100M      (clk_100M),
        .rst_n         (rst_n),
        .run           (busy),
        .noise_en      (noise_en),
        .noise_rate    (noise_rate),
        .glitch_len    (glitch_len),
        .glitch_active (glitch_active)
    );

endmodule

// File: tb/tb_sq_sig_gen.sv
// Directed self-checking bench for sq_sig_gen.
module tb_sq_sig_gen;

    logic        clk_100M = 1'b0;
    logic        rst_n    = 1'b0;
    logic        en       = 1'b0;
    logic [31:0] period   = 32'd0;
    logic [31:0] high_len = 32'd0;
    logic        noise_en = 1'b0;
    logic [7:0]  noise_rate = 8'd0;
    logic [7:0]  glitch_len = 8'd0;
    logic        sq_sig, sq_sig_noisy, period_tick, busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_100M = ~clk_100M;

    sq_sig_gen dut (
        .clk_100M     (clk_100M),
        .rst_n        (rst_n),
        .en           (en),
        .period       (period),
        .high_len     (high_len),
        .noise_en     (noise_en),
        .noise_rate   (noise_rate),
        .glitch_len   (glitch_len),
        .sq_sig       (sq_sig),
        .sq_sig_noisy (sq_sig_noisy),
        .period_tick  (period_tick),
        .busy         (busy)
    );

    // Reference glitch model: independent LFSR + counter, counts glitch starts.
    logic [15:0] m_lfsr;
    logic [7:0]  m_cnt;
    logic        m_run;
    int          m_starts;
    logic        t6_on = 1'b0;

    always @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            m_lfsr   <= 16'hACE1;
            m_cnt    <= 8'd0;
            m_run    <= 1'b0;
            m_starts <= 0;
        end else begin
            m_run <= en && (period != 0);
            if (noise_en)
                m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
            if (!m_run)
                m_cnt <= 8'd0;
            else if (m_cnt == 0 && noise_en && glitch_len != 0 && m_lfsr[7:0] < noise_rate) begin
                m_cnt <= glitch_len;
                if (t6_on) m_starts <= m_starts + 1;
            end else if (m_cnt != 0)
                m_cnt <= m_cnt - 8'd1;
        end
    end

    task automatic go_idle();
        en = 1'b0;
        repeat (3) @(negedge clk_100M);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk_100M);
        n_checks++;
        if ({sq_sig, sq_sig_noisy, period_tick, busy} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b need 0000", {sq_sig, sq_sig_noisy, period_tick, busy});
        end
        rst_n = 1'b1;
        @(negedge clk_100M);
        n_checks++;
        if ({sq_sig, period_tick, busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL idle_after_reset: got %b need 000", {sq_sig, period_tick, busy});
        end
    endtask

    task automatic test_basic();
        period = 10; high_len = 3; en = 1'b1;
        @(negedge clk_100M);
        n_checks++;
        if ({busy, sq_sig, period_tick} !== 3'b100) begin
            n_fail++;
            $display("FAIL t1_first_cycle: got %b need 100", {busy, sq_sig, period_tick});
        end
        for (int i = 0; i < 30; i++) begin
            @(negedge clk_100M);
            n_checks++;
            if (sq_sig !== ((i % 10) < 3) || period_tick !== ((i % 10) == 0) || sq_sig_noisy !== sq_sig) begin
                n_fail++;
                $display("FAIL t1_wave i=%0d: got sq=%b tick=%b noisy=%b need sq=%b tick=%b",
                         i, sq_sig, period_tick, sq_sig_noisy, (i % 10) < 3, (i % 10) == 0);
            end
        end
        go_idle();
    endtask

    task automatic test_edges();
        logic [31:0] pv [3] = '{32'd10, 32'd10, 32'd1};
        logic [31:0] hv [3] = '{32'd0, 32'd12, 32'd1};
        logic        sv [3] = '{1'b0, 1'b1, 1'b1};
        for (int c = 0; c < 3; c++) begin
            period = pv[c]; high_len = hv[c]; en = 1'b1;
            @(negedge clk_100M);
            for (int i = 0; i < 25; i++) begin
                @(negedge clk_100M);
                n_checks++;
                if (sq_sig !== sv[c] || period_tick !== ((i % pv[c]) == 0)) begin
                    n_fail++;
                    $display("FAIL t2_edge case=%0d i=%0d: got sq=%b tick=%b need sq=%b tick=%b",
                             c, i, sq_sig, period_tick, sv[c], (i % pv[c]) == 0);
                end
            end
            go_idle();
        end
    endtask

    task automatic test_mid_change();
        logic exp_sq, exp_tk;
        period = 10; high_len = 5; en = 1'b1;
        @(negedge clk_100M);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_100M);
            if (i < 10) begin
                exp_sq = (i < 5);
                exp_tk = (i == 0);
            end else begin
                exp_sq = ((i - 10) % 20) < 2;
                exp_tk = ((i - 10) % 20) == 0;
            end
            n_checks++;
            if (sq_sig !== exp_sq || period_tick !== exp_tk) begin
                n_fail++;
                $display("FAIL t3_change i=%0d: got sq=%b tick=%b need sq=%b tick=%b",
                         i, sq_sig, period_tick, exp_sq, exp_tk);
            end
            if (i == 4) begin
                period = 20; high_len = 2;
            end
        end
        go_idle();
    endtask

    task automatic test_disable();
        period = 10; high_len = 5; en = 1'b1;
        repeat (4) @(negedge clk_100M);  // observes phases 0,1,2
        en = 1'b0;
        @(negedge clk_100M);
        n_checks++;
        if ({busy, sq_sig, sq_sig_noisy, period_tick} !== 4'b0000) begin
            n_fail++;
            $display("FAIL t4_disable: got %b need 0000", {busy, sq_sig, sq_sig_noisy, period_tick});
        end
        en = 1'b1;
        @(negedge clk_100M);
        n_checks++;
        if ({busy, sq_sig, period_tick} !== 3'b100) begin
            n_fail++;
            $display("FAIL t4_reenable_latch: got %b need 100", {busy, sq_sig, period_tick});
        end
        @(negedge clk_100M);
        n_checks++;
        if ({sq_sig, period_tick} !== 2'b11) begin
            n_fail++;
            $display("FAIL t4_restart_phase0: got %b need 11", {sq_sig, period_tick});
        end
        @(negedge clk_100M);
        n_checks++;
        if ({sq_sig, period_tick} !== 2'b10) begin
            n_fail++;
            $display("FAIL t4_restart_phase1: got %b need 10", {sq_sig, period_tick});
        end
        go_idle();
        period = 0; high_len = 5; en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_100M);
            n_checks++;
            if ({busy, sq_sig, period_tick} !== 3'b000) begin
                n_fail++;
                $display("FAIL t4_zero_period i=%0d: got %b need 000", i, {busy, sq_sig, period_tick});
            end
        end
        go_idle();
    endtask

    task automatic test_noise_off();
        int bad0 = 0, bad1 = 0;
        period = 100; high_len = 37; noise_en = 1'b1; noise_rate = 8'd0; glitch_len = 8'd4;
        en = 1'b1;
        repeat (10000) begin
            @(negedge clk_100M);
            if (sq_sig_noisy !== sq_sig) bad0++;
        end
        n_checks++;
        if (bad0 != 0) begin
            n_fail++;
            $display("FAIL t5_rate0: %0d differing cycles, need 0", bad0);
        end
        noise_rate = 8'd128; glitch_len = 8'd0;
        repeat (10000) begin
            @(negedge clk_100M);
            if (sq_sig_noisy !== sq_sig) bad1++;
        end
        n_checks++;
        if (bad1 != 0) begin
            n_fail++;
            $display("FAIL t5_len0: %0d differing cycles, need 0", bad1);
        end
        noise_en = 1'b0;
        go_idle();
    endtask

    task automatic test_noise_on();
        int  runs = 0, run_len = 0, wait_cyc = 0;
        rst_n = 1'b0;
        en = 1'b0; period = 1000; high_len = 500;
        noise_en = 1'b1; noise_rate = 8'd128; glitch_len = 8'd4;
        t6_on = 1'b1;
        @(negedge clk_100M);
        rst_n = 1'b1; en = 1'b1;
        for (int i = 0; i < 3010; i++) begin
            if (i == 3000) noise_en = 1'b0;
            @(negedge clk_100M);
            if (sq_sig_noisy !== sq_sig) begin
                run_len++;
            end else if (run_len != 0) begin
                n_checks++;
                if (run_len != 4) begin
                    n_fail++;
                    $display("FAIL t6_run_len: got %0d need 4", run_len);
                end
                runs++;
                run_len = 0;
            end
        end
        t6_on = 1'b0;
        n_checks++;
        if (runs != m_starts || runs == 0) begin
            n_fail++;
            $display("FAIL t6_run_count: got %0d need %0d (nonzero)", runs, m_starts);
        end
        // Reset in the middle of a glitch.
        noise_en = 1'b1;
        while (sq_sig_noisy === sq_sig && wait_cyc < 500) begin
            @(negedge clk_100M);
            wait_cyc++;
        end
        n_checks++;
        if (wait_cyc >= 500) begin
            n_fail++;
            $display("FAIL t6_glitch_wait: no glitch within %0d cycles", wait_cyc);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({sq_sig, sq_sig_noisy, period_tick, busy} !== 4'b0000) begin
            n_fail++;
            $display("FAIL t6_async_reset: got %b need 0000", {sq_sig, sq_sig_noisy, period_tick, busy});
        end
        en = 1'b0;
        @(negedge clk_100M);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_100M);
            n_checks++;
            if ({sq_sig, sq_sig_noisy, busy} !== 3'b000) begin
                n_fail++;
                $display("FAIL t6_after_reset i=%0d: got %b need 000", i, {sq_sig, sq_sig_noisy, busy});
            end
        end
        noise_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_edges();
        test_mid_change();
        test_disable();
        test_noise_off();
        test_noise_on();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
